pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 24 ++
 rtl/pipe_hazard_det.sv | 33 +++
 rtl/pipe_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_pkg
//  Description : Shared types and constants for the pipeline controller.
//                Holds the FSM state encoding and the hardwired-zero
//                register number used by the load-use comparator.
//  Revision    : 1.0  initial release
// ============================================================================
package pipe_ctrl_pkg;

    // Encoding 2'd3 is deliberately left unused; the controller recovers
    // from it to RUN on the next clock edge.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    // Register r0 is hardwired to zero, so a load targeting it never
    // creates a real dependency.
    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_hazard_det.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_det
//  Description : Combinational load-use detector. Flags when the load in EX
//                writes a non-zero register that the instruction in ID reads.
//  Revision    : 1.0  initial release
//
//  Ports
//    ex_mem_read : in  1  EX-stage instruction is a load
//    ex_rt       : in  5  EX-stage load destination register
//    id_rs       : in  5  ID-stage rs register number
//    id_rt       : in  5  ID-stage rt register number
//    load_use    : out 1  load-use dependency present
// ============================================================================
module pipe_hazard_det
    import pipe_ctrl_pkg::*;
(
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    output logic       load_use
);

    logic w_rs_match;
    logic w_rt_match;

    assign w_rs_match = (ex_rt == id_rs);
    assign w_rt_match = (ex_rt == id_rt);
    assign load_use   = ex_mem_read & (ex_rt != REG_ZERO) & (w_rs_match | w_rt_match);

endmodule : pipe_hazard_det
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl
//  Description : Five-stage pipeline controller. Generates PC / pipeline
//                register load enables, the ID/EX bubble and the flush
//                requests from data-memory wait, memory timeout, taken
//                branches in MEM and load-use hazards.
//                Priority: freeze > timeout/FLUSH > branch > load-use > normal.
//  Revision    : 1.0  initial release
//
//  Build option
//    PIPE_PERF_CNT_EN : when defined, StallCount counts cycles with
//                       PcWrite = 0 (saturating). Otherwise it reads 0.
//
//  Parameters
//    MAX_WAIT : MEM_WAIT cycles before timeout (1..255)
//
//  Ports
//    Clk            : in  1   clock, rising edge
//    Rst_n          : in  1   asynchronous active-low reset
//    IdRs, IdRt     : in  5   ID-stage source registers
//    ExMemRead      : in  1   EX-stage instruction is a load
//    ExRt           : in  5   EX-stage load destination
//    MemReq         : in  1   MEM stage accessing data memory
//    MemReady       : in  1   data memory completes this cycle
//    MemBranchTaken : in  1   MEM-stage branch resolved taken
//    PcWrite..MemWbWrite : out 1 each  load enables
//    IdExBubble     : out 1   load zeroed control word into ID/EX
//    FlushIfId/IdEx/ExMem : out 1 each synchronous-clear requests
//    MemErr         : out 1   one-cycle timeout pulse (registered)
//    State          : out 2   current FSM state
//    StallCount     : out 16  stall-cycle count
// ============================================================================
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 8
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [4:0]  IdRs,
    input  logic [4:0]  IdRt,
    input  logic        ExMemRead,
    input  logic [4:0]  ExRt,
    input  logic        MemReq,
    input  logic        MemReady,
    input  logic        MemBranchTaken,
    output logic        PcWrite,
    output logic        IfIdWrite,
    output logic        IdExWrite,
    output logic        ExMemWrite,
    output logic        MemWbWrite,
    output logic        IdExBubble,
    output logic        FlushIfId,
    output logic        FlushIdEx,
    output logic        FlushExMem,
    output logic        MemErr,
    output logic [1:0]  State,
    output logic [15:0] StallCount
);

    // The wait counter starts at 0 on the first MEM_WAIT cycle, so the
    // MAX_WAIT-th MEM_WAIT cycle is the one holding MAX_WAIT-1.
    localparam logic [7:0] c_WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t      r_state;
    logic [7:0]  r_wait_cnt;
    logic        r_mem_err;

    logic        w_load_use;
    logic        w_in_run;
    logic        w_in_wait;
    logic        w_freeze;

    pipe_hazard_det u_hazard_det (
        .ex_mem_read (ExMemRead),
        .ex_rt       (ExRt),
        .id_rs       (IdRs),
        .id_rt       (IdRt),
        .load_use    (w_load_use)
    );

    assign w_in_run  = (r_state == RUN);
    assign w_in_wait = (r_state == MEM_WAIT);
    assign w_freeze  = (w_in_run & MemReq & ~MemReady) | (w_in_wait & ~MemReady);

    // ------------------------------------------------------------------
    // Controller FSM with registered State and MemErr
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state    <= RUN;
            r_wait_cnt <= 8'd0;
            r_mem_err  <= 1'b0;
        end else begin
            r_mem_err <= 1'b0;
            case (r_state)
                RUN: begin
                    // A taken branch in RUN flushes but keeps the state.
                    if (MemReq && !MemReady) begin
                        r_state    <= MEM_WAIT;
                        r_wait_cnt <= 8'd0;
                    end
                end
                MEM_WAIT: begin
                    if (MemReady) begin
                        r_state <= RUN;
                    end else if (r_wait_cnt == c_WAIT_LAST) begin
                        r_state   <= FLUSH;
                        r_mem_err <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                FLUSH: begin
                    r_state <= RUN;
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end

    assign State  = r_state;
    assign MemErr = r_mem_err;

    // ------------------------------------------------------------------
    // Combinational enables, bubble and flushes
    // ------------------------------------------------------------------
    always_comb begin
        PcWrite    = 1'b1;
        IfIdWrite  = 1'b1;
        IdExWrite  = 1'b1;
        ExMemWrite = 1'b1;
        MemWbWrite = 1'b1;
        IdExBubble = 1'b0;
        FlushIfId  = 1'b0;
        FlushIdEx  = 1'b0;
        FlushExMem = 1'b0;

        if (!Rst_n) begin
            // Hold the pipeline still and cleared while in reset.
            PcWrite    = 1'b0;
            IfIdWrite  = 1'b0;
            IdExWrite  = 1'b0;
            ExMemWrite = 1'b0;
            MemWbWrite = 1'b0;
            FlushIfId  = 1'b1;
            FlushIdEx  = 1'b1;
            FlushExMem = 1'b1;
        end else if (w_freeze) begin
            PcWrite    = 1'b0;
            IfIdWrite  = 1'b0;
            IdExWrite  = 1'b0;
            ExMemWrite = 1'b0;
            MemWbWrite = 1'b0;
        end else if ((r_state == FLUSH) || MemBranchTaken) begin
            FlushIfId  = 1'b1;
            FlushIdEx  = 1'b1;
            FlushExMem = 1'b1;
        end else if (w_load_use) begin
            // Hold PC and IF/ID for one cycle; ID/EX takes a bubble while
            // the older instructions keep draining.
            PcWrite    = 1'b0;
            IfIdWrite  = 1'b0;
            IdExBubble = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Optional stall-cycle counter
    // ------------------------------------------------------------------
`ifdef PIPE_PERF_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_stall_cnt <= 16'd0;
        end else if (!PcWrite && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign StallCount = r_stall_cnt;
`else
    assign StallCount = 16'd0;
`endif

endmodule : pipe_ctrl
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_ctrl
//  Description : Self-checking bench for pipe_ctrl (MAX_WAIT = 4).
//                Single-cycle vectors in RUN from a table, then hand-written
//                sequences for memory wait, ready+branch, timeout and
//                reset during MEM_WAIT.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_ctrl;

    logic        Clk;
    logic        Rst_n;
    logic [4:0]  IdRs, IdRt, ExRt;
    logic        ExMemRead, MemReq, MemReady, MemBranchTaken;
    logic        PcWrite, IfIdWrite, IdExWrite, ExMemWrite, MemWbWrite;
    logic        IdExBubble, FlushIfId, FlushIdEx, FlushExMem, MemErr;
    logic [1:0]  State;
    logic [15:0] StallCount;

    int n_checks = 0;
    int n_err    = 0;
    int exp_stall = 0;

    pipe_ctrl #(.MAX_WAIT(4)) dut (
        .Clk            (Clk),
        .Rst_n          (Rst_n),
        .IdRs           (IdRs),
        .IdRt           (IdRt),
        .ExMemRead      (ExMemRead),
        .ExRt           (ExRt),
        .MemReq         (MemReq),
        .MemReady       (MemReady),
        .MemBranchTaken (MemBranchTaken),
        .PcWrite        (PcWrite),
        .IfIdWrite      (IfIdWrite),
        .IdExWrite      (IdExWrite),
        .ExMemWrite     (ExMemWrite),
        .MemWbWrite     (MemWbWrite),
        .IdExBubble     (IdExBubble),
        .FlushIfId      (FlushIfId),
        .FlushIdEx      (FlushIdEx),
        .FlushExMem     (FlushExMem),
        .MemErr         (MemErr),
        .State          (State),
        .StallCount     (StallCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       ex_rd;
        logic [4:0] ex_rt;
        logic       req;
        logic       rdy;
        logic       br;
    } in_t;

    typedef struct {
        in_t        inp;
        logic [11:0] exp;
    } vec_t;

    // Expected-word layout: {Pc,IfId,IdEx,ExMem,MemWb, FlIfId,FlIdEx,FlExMem,
    //                        Bubble, State[1:0], MemErr}
    localparam logic [4:0] EN_ALL  = 5'b11111;
    localparam logic [4:0] EN_NONE = 5'b00000;
    localparam logic [4:0] EN_LU   = 5'b00111;
    localparam logic [2:0] FL_ALL  = 3'b111;
    localparam logic [2:0] FL_NONE = 3'b000;

    function automatic in_t mk(input logic [4:0] rs, input logic [4:0] rt,
                               input logic ex_rd, input logic [4:0] ex_rt,
                               input logic req, input logic rdy, input logic br);
        in_t r;
        r.rs = rs; r.rt = rt; r.ex_rd = ex_rd; r.ex_rt = ex_rt;
        r.req = req; r.rdy = rdy; r.br = br;
        return r;
    endfunction

    function automatic logic [11:0] ex(input logic [4:0] en, input logic [2:0] fl,
                                       input logic b, input logic [1:0] st,
                                       input logic me);
        return {en, fl, b, st, me};
    endfunction

    function automatic logic [11:0] act_word();
        return {PcWrite, IfIdWrite, IdExWrite, ExMemWrite, MemWbWrite,
                FlushIfId, FlushIdEx, FlushExMem, IdExBubble, State, MemErr};
    endfunction

    function automatic logic [15:0] exp_sc();
`ifdef PIPE_PERF_CNT_EN
        return (exp_stall > 65535) ? 16'hFFFF : 16'(exp_stall);
`else
        return 16'd0;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply_check(input in_t v, input logic [11:0] exp, input string name);
        IdRs = v.rs; IdRt = v.rt; ExMemRead = v.ex_rd; ExRt = v.ex_rt;
        MemReq = v.req; MemReady = v.rdy; MemBranchTaken = v.br;
        #1;
        chk(name, 32'(act_word()), 32'(exp));
    endtask

    // Clock the current cycle and return at the following falling edge.
    task automatic advance(input logic [11:0] exp);
        @(posedge Clk);
        if (exp[11] == 1'b0) exp_stall++;
        @(negedge Clk);
    endtask

    task automatic step(input in_t v, input logic [11:0] exp, input string name);
        apply_check(v, exp, name);
        advance(exp);
    endtask

    vec_t vecs[12];
    in_t  idle;
    in_t  lu;

    initial begin
        idle = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        lu   = mk(5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);

        vecs[0]  = '{mk(5'd0, 5'd0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0), ex(EN_ALL, FL_NONE, 1'b0, 2'd0, 1'b0)};
        vecs[1]  = '{mk(5'd5, 5'd0, 1'b1, 5'd5,  1'b0, 1'b0, 1'b0), ex(EN_LU,  FL_NONE, 1'b1, 2'd0, 1'b0)};
        vecs[2]  = '{mk(5'd3, 5'd7, 1'b1, 5'd7,  1'b0, 1'b0, 1'b0), ex(EN_LU,  FL_NONE, 1'b1, 2'd0, 1'b0)};
        vecs[3]  = '{mk(5'd0, 5'd0, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0), ex(EN_ALL, FL_NONE, 1'b0, 2'd0, 1'b0)};
        vecs[4]  = '{mk(5'd5, 5'd0, 1'b0, 5'd5,  1'b0, 1'b0, 1'b0), ex(EN_ALL, FL_NONE, 1'b0, 2'd0, 1'b0)};
        vecs[5]  = '{mk(5'd6, 5'd4, 1'b1, 5'd5,  1'b0, 1'b0, 1'b0), ex(EN_ALL, FL_NONE, 1'b0, 2'd0, 1'b0)};
        vecs[6]  = '{mk(5'd5, 5'd0, 1'b1, 5'd5,  1'b0, 1'b0, 1'b1), ex(EN_ALL, FL_ALL,  1'b0, 2'd0, 1'b0)};
        vecs[7]  = '{mk(5'd1, 5'd2, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1), ex(EN_ALL, FL_ALL,  1'b0, 2'd0, 1'b0)};
        vecs[8]  = '{mk(5'd1, 5'd2, 1'b0, 5'd0,  1'b1, 1'b1, 1'b0), ex(EN_ALL, FL_NONE, 1'b0, 2'd0, 1'b0)};
        vecs[9]  = '{mk(5'd1, 5'd2, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0), ex(EN_ALL, FL_NONE, 1'b0, 2'd0, 1'b0)};
        vecs[10] = '{mk(5'd9, 5'd2, 1'b1, 5'd9,  1'b1, 1'b1, 1'b0), ex(EN_LU,  FL_NONE, 1'b1, 2'd0, 1'b0)};
        vecs[11] = '{mk(5'd4, 5'd31, 1'b1, 5'd31, 1'b0, 1'b0, 1'b0), ex(EN_LU, FL_NONE, 1'b1, 2'd0, 1'b0)};

        // ---------------- reset state ----------------
        Rst_n = 1'b0;
        IdRs = '0; IdRt = '0; ExRt = '0;
        ExMemRead = 1'b0; MemReq = 1'b0; MemReady = 1'b0; MemBranchTaken = 1'b0;
        repeat (2) @(negedge Clk);
        #1;
        chk("reset_outputs", 32'(act_word()), 32'(ex(EN_NONE, FL_ALL, 1'b0, 2'd0, 1'b0)));
        chk("reset_stallcount", 32'(StallCount), 32'(16'd0));
        Rst_n = 1'b1;
        @(negedge Clk);

        // ---------------- table vectors in RUN ----------------
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].inp, vecs[i].exp, $sformatf("vec%0d", i));
        end
        chk("stallcount_after_table", 32'(StallCount), 32'(exp_sc()));

        // ---------------- memory wait, 3 not-ready cycles ----------------
        step(mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0), ex(EN_NONE, FL_NONE, 1'b0, 2'd0, 1'b0), "wait_run_freeze");
        // branch + load-use while frozen: freeze wins
        step(mk(5'd5, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1), ex(EN_NONE, FL_NONE, 1'b0, 2'd1, 1'b0), "wait_frozen_br_lu");
        step(mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0), ex(EN_NONE, FL_NONE, 1'b0, 2'd1, 1'b0), "wait_frozen");
        step(mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0), ex(EN_ALL,  FL_NONE, 1'b0, 2'd1, 1'b0), "wait_ready");
        step(idle, ex(EN_ALL, FL_NONE, 1'b0, 2'd0, 1'b0), "wait_back_run");
        chk("stallcount_after_wait", 32'(StallCount), 32'(exp_sc()));

        // ---------------- MemReady + branch in MEM_WAIT ----------------
        step(mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0), ex(EN_NONE, FL_NONE, 1'b0, 2'd0, 1'b0), "rb_run_freeze");
        step(mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0), ex(EN_NONE, FL_NONE, 1'b0, 2'd1, 1'b0), "rb_frozen");
        step(mk(5'd5, 5'd0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1), ex(EN_ALL,  FL_ALL,  1'b0, 2'd1, 1'b0), "rb_ready_branch");
        step(idle, ex(EN_ALL, FL_NONE, 1'b0, 2'd0, 1'b0), "rb_back_run");

        // ---------------- timeout with MAX_WAIT = 4 ----------------
        step(mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0), ex(EN_NONE, FL_NONE, 1'b0, 2'd0, 1'b0), "to_run_freeze");
        for (int k = 0; k < 4; k++) begin
            step(mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0), ex(EN_NONE, FL_NONE, 1'b0, 2'd1, 1'b0),
                 $sformatf("to_wait%0d", k));
        end
        // FLUSH cycle: MemErr pulse, full flush, load-use ignored
        step(mk(5'd5, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0), ex(EN_ALL, FL_ALL, 1'b0, 2'd2, 1'b1), "to_flush");
        step(idle, ex(EN_ALL, FL_NONE, 1'b0, 2'd0, 1'b0), "to_back_run");
        chk("stallcount_after_timeout", 32'(StallCount), 32'(exp_sc()));

        // ---------------- reset during MEM_WAIT ----------------
        step(mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0), ex(EN_NONE, FL_NONE, 1'b0, 2'd0, 1'b0), "rst_run_freeze");
        apply_check(mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0), ex(EN_NONE, FL_NONE, 1'b0, 2'd1, 1'b0), "rst_in_wait");
        #1;
        Rst_n = 1'b0;
        exp_stall = 0;
        #1;
        chk("rst_async", 32'(act_word()), 32'(ex(EN_NONE, FL_ALL, 1'b0, 2'd0, 1'b0)));
        @(posedge Clk);
        #1;
        chk("rst_held", 32'(act_word()), 32'(ex(EN_NONE, FL_ALL, 1'b0, 2'd0, 1'b0)));
        @(negedge Clk);
        Rst_n = 1'b1;
        step(idle, ex(EN_ALL, FL_NONE, 1'b0, 2'd0, 1'b0), "rst_release_run");
        chk("rst_stallcount_cleared", 32'(StallCount), 32'(exp_sc()));
        step(lu, ex(EN_LU, FL_NONE, 1'b1, 2'd0, 1'b0), "rst_after_loaduse");
        step(mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0), ex(EN_NONE, FL_NONE, 1'b0, 2'd0, 1'b0), "rst_after_freeze");
        step(mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0), ex(EN_ALL,  FL_NONE, 1'b0, 2'd1, 1'b0), "rst_after_ready");
        step(idle, ex(EN_ALL, FL_NONE, 1'b0, 2'd0, 1'b0), "rst_after_run");
        chk("final_stallcount", 32'(StallCount), 32'(exp_sc()));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_pipe_ctrl
`default_nettype wire
